// File: rtl/delay_pkg.sv
// Shared definitions for the delay tap scheduler.
//   - default line depths
//   - FSM state enum
//   - depth lookup helper (parameter mux of the four line depths)
package delay_pkg;

  localparam int unsigned DEF_DEPTH0 = 30;
  localparam int unsigned DEF_DEPTH1 = 45;
  localparam int unsigned DEF_DEPTH2 = 60;
  localparam int unsigned DEF_DEPTH3 = 90;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } state_t;

  function automatic int unsigned depth_of(
    input logic [1:0]  sel,
    input int unsigned d0,
    input int unsigned d1,
    input int unsigned d2,
    input int unsigned d3
  );
    case (sel)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

endpackage

// File: rtl/fill_tracker.sv
// Fill tracker: counts edges since reset, saturating at the deepest line,
// and reports per line whether that line has been completely refilled.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   fill_cnt        edges since reset, saturated at DEPTH3
//   line_ready[i]   fill_cnt >= depth of line i
module fill_tracker
  import delay_pkg::*;
#(
  parameter int unsigned DEPTH0 = DEF_DEPTH0,
  parameter int unsigned DEPTH1 = DEF_DEPTH1,
  parameter int unsigned DEPTH2 = DEF_DEPTH2,
  parameter int unsigned DEPTH3 = DEF_DEPTH3,
  parameter int unsigned CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] fill_cnt,
  output logic [3:0]       line_ready
);

  // Runs regardless of enable: the lines shift on every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (fill_cnt < CNT_W'(DEPTH3)) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ready
    assign line_ready[i] =
      (fill_cnt >= CNT_W'(depth_of(2'(i), DEPTH0, DEPTH1, DEPTH2, DEPTH3)));
  end

endmodule

// File: rtl/delay_tap_scheduler.sv
// Delay tap scheduler: accepts tap-change requests, drives the output mux
// select, blanks the mux across every switch and while the selected line
// is still filling, and flags when the selected line carries genuine data.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   ena                  design enable
//   cfg_valid, cfg_tap   tap-change request and requested line
//   cfg_ready            request can be taken this cycle (combinational)
//   tap_sel              registered mux select
//   blank                registered mux output force-to-zero
//   out_valid            registered, selected line output is genuine
//   switch_cnt           saturating count of effective switches
//
// state | meaning
// FILL  | selected line not yet full since reset, output blanked
// RUN   | selected line full, output valid
// GUARD | blanking window after a tap switch
module delay_tap_scheduler
  import delay_pkg::*;
#(
  parameter int unsigned DEPTH0       = DEF_DEPTH0,
  parameter int unsigned DEPTH1       = DEF_DEPTH1,
  parameter int unsigned DEPTH2       = DEF_DEPTH2,
  parameter int unsigned DEPTH3       = DEF_DEPTH3,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned CNT_W        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_tap,
  output logic       cfg_ready,
  output logic [1:0] tap_sel,
  output logic       blank,
  output logic       out_valid,
  output logic [7:0] switch_cnt
);

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [1:0]        tap_nxt;
  logic [GW-1:0]     guard_cnt, guard_nxt;
  logic              cnt_inc;
  logic              blank_nxt, out_valid_nxt;
  logic [CNT_W-1:0]  fill_cnt;
  logic [3:0]        line_ready;
  logic              sel_ready;
  logic              accept, switching;

  fill_tracker #(
    .DEPTH0 (DEPTH0),
    .DEPTH1 (DEPTH1),
    .DEPTH2 (DEPTH2),
    .DEPTH3 (DEPTH3),
    .CNT_W  (CNT_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .fill_cnt   (fill_cnt),
    .line_ready (line_ready)
  );

  assign sel_ready = line_ready[tap_sel];
  assign cfg_ready = ena & ~rst & (state != GUARD);
  assign accept    = cfg_valid & cfg_ready;
  assign switching = accept & (cfg_tap != tap_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      tap_sel    <= 2'd0;
      guard_cnt  <= '0;
      switch_cnt <= 8'd0;
      blank      <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tap_sel   <= tap_nxt;
      guard_cnt <= guard_nxt;
      blank     <= blank_nxt;
      out_valid <= out_valid_nxt;
      if (cnt_inc && (switch_cnt != 8'hFF)) begin
        switch_cnt <= switch_cnt + 8'd1;
      end
    end
  end

  // A same-tap accept still wins over FILL->RUN, so the state simply holds.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap_sel;
    guard_nxt = guard_cnt;
    cnt_inc   = 1'b0;
    if (ena) begin
      case (state)
        FILL, RUN: begin
          if (switching) begin
            state_nxt = GUARD;
            tap_nxt   = cfg_tap;
            guard_nxt = GW'(GUARD_CYCLES - 1);
            cnt_inc   = 1'b1;
          end else if (!accept && (state == FILL) && sel_ready) begin
            state_nxt = RUN;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state_nxt = sel_ready ? RUN : FILL;
          end else begin
            guard_nxt = guard_cnt - GW'(1);
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // Flags follow the state being entered; a disabled design is always blanked.
  always_comb begin
    out_valid_nxt = ena && (state_nxt == RUN);
    blank_nxt     = !out_valid_nxt;
  end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
module tb_delay_tap_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       cfg_valid;
  logic [1:0] cfg_tap;
  logic       cfg_ready;
  logic [1:0] tap_sel;
  logic       blank;
  logic       out_valid;
  logic [7:0] switch_cnt;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;

  delay_tap_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cfg_valid  (cfg_valid),
    .cfg_tap    (cfg_tap),
    .cfg_ready  (cfg_ready),
    .tap_sel    (tap_sel),
    .blank      (blank),
    .out_valid  (out_valid),
    .switch_cnt (switch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; cfg_valid = 1'b0; cfg_tap = 2'd0;
    step(); step(); step();
    total++; if (tap_sel !== 2'd0) $display("FAIL rst_tap_sel got=%0d exp=0", tap_sel); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL rst_blank got=%0b exp=1", blank); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (switch_cnt !== 8'd0) $display("FAIL rst_switch_cnt got=%0d exp=0", switch_cnt); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready got=%0b exp=0", cfg_ready); else passed++;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_initial_fill();
    step_to(30);
    total++; if (out_valid !== 1'b0) $display("FAIL fill_ov_e30 got=%0b exp=0", out_valid); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL fill_blank_e30 got=%0b exp=1", blank); else passed++;
    step_to(31);
    total++; if (out_valid !== 1'b1) $display("FAIL fill_ov_e31 got=%0b exp=1", out_valid); else passed++;
    total++; if (blank !== 1'b0) $display("FAIL fill_blank_e31 got=%0b exp=0", blank); else passed++;
    total++; if (tap_sel !== 2'd0) $display("FAIL fill_tap_e31 got=%0d exp=0", tap_sel); else passed++;
  endtask

  task automatic test_switch_unfilled();
    step_to(40);
    cfg_valid = 1'b1; cfg_tap = 2'd3;
    #1;
    total++; if (cfg_ready !== 1'b1) $display("FAIL sw3_ready_run got=%0b exp=1", cfg_ready); else passed++;
    step();
    cfg_valid = 1'b0;
    total++; if (tap_sel !== 2'd3) $display("FAIL sw3_tap got=%0d exp=3", tap_sel); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL sw3_blank_e41 got=%0b exp=1", blank); else passed++;
    total++; if (switch_cnt !== 8'd1) $display("FAIL sw3_count got=%0d exp=1", switch_cnt); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL sw3_ready_e41 got=%0b exp=0", cfg_ready); else passed++;
    step();
    total++; if (cfg_ready !== 1'b0) $display("FAIL sw3_ready_e42 got=%0b exp=0", cfg_ready); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL sw3_blank_e42 got=%0b exp=1", blank); else passed++;
    step();
    total++; if (cfg_ready !== 1'b1) $display("FAIL sw3_ready_e43 got=%0b exp=1", cfg_ready); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL sw3_blank_e43 got=%0b exp=1", blank); else passed++;
    step_to(90);
    total++; if (out_valid !== 1'b0) $display("FAIL sw3_ov_e90 got=%0b exp=0", out_valid); else passed++;
    step_to(91);
    total++; if (out_valid !== 1'b1) $display("FAIL sw3_ov_e91 got=%0b exp=1", out_valid); else passed++;
  endtask

  task automatic test_switch_filled();
    step_to(100);
    cfg_valid = 1'b1; cfg_tap = 2'd2;
    step();
    cfg_valid = 1'b0;
    total++; if (tap_sel !== 2'd2) $display("FAIL sw2_tap got=%0d exp=2", tap_sel); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL sw2_ov_e101 got=%0b exp=0", out_valid); else passed++;
    step();
    total++; if (blank !== 1'b1) $display("FAIL sw2_blank_e102 got=%0b exp=1", blank); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL sw2_ov_e103 got=%0b exp=1", out_valid); else passed++;
    total++; if (blank !== 1'b0) $display("FAIL sw2_blank_e103 got=%0b exp=0", blank); else passed++;
    total++; if (switch_cnt !== 8'd2) $display("FAIL sw2_count got=%0d exp=2", switch_cnt); else passed++;
  endtask

  task automatic test_same_tap();
    cfg_valid = 1'b1; cfg_tap = 2'd2;
    step();
    cfg_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL same_ov got=%0b exp=1", out_valid); else passed++;
    total++; if (switch_cnt !== 8'd2) $display("FAIL same_count got=%0d exp=2", switch_cnt); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL same_ready got=%0b exp=1", cfg_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1; cfg_tap = 2'd1;
    step();
    cfg_tap = 2'd0;
    total++; if (tap_sel !== 2'd1) $display("FAIL b2b_tap_e105 got=%0d exp=1", tap_sel); else passed++;
    total++; if (switch_cnt !== 8'd3) $display("FAIL b2b_count_e105 got=%0d exp=3", switch_cnt); else passed++;
    step();
    total++; if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_e106 got=%0b exp=0", cfg_ready); else passed++;
    total++; if (tap_sel !== 2'd1) $display("FAIL b2b_tap_e106 got=%0d exp=1", tap_sel); else passed++;
    step();
    total++; if (tap_sel !== 2'd1) $display("FAIL b2b_tap_e107 got=%0d exp=1", tap_sel); else passed++;
    total++; if (switch_cnt !== 8'd3) $display("FAIL b2b_count_e107 got=%0d exp=3", switch_cnt); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_ov_e107 got=%0b exp=1", out_valid); else passed++;
    step();
    cfg_valid = 1'b0;
    total++; if (tap_sel !== 2'd0) $display("FAIL b2b_tap_e108 got=%0d exp=0", tap_sel); else passed++;
    total++; if (switch_cnt !== 8'd4) $display("FAIL b2b_count_e108 got=%0d exp=4", switch_cnt); else passed++;
    step_to(110);
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_ov_e110 got=%0b exp=1", out_valid); else passed++;
  endtask

  task automatic test_disable();
    ena = 1'b0;
    #1;
    total++; if (cfg_ready !== 1'b0) $display("FAIL dis_ready got=%0b exp=0", cfg_ready); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL dis_ov_%0d got=%0b exp=0", i, out_valid); else passed++;
      total++; if (blank !== 1'b1) $display("FAIL dis_blank_%0d got=%0b exp=1", i, blank); else passed++;
    end
    ena = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL dis_ov_resume got=%0b exp=1", out_valid); else passed++;
    total++; if (dut.u_fill.fill_cnt !== 7'd90) $display("FAIL dis_fill_cnt got=%0d exp=90", dut.u_fill.fill_cnt); else passed++;
  endtask

  task automatic test_reset_mid_run_fill();
    rst = 1'b1; cfg_valid = 1'b1; cfg_tap = 2'd2;
    #1;
    total++; if (cfg_ready !== 1'b0) $display("FAIL rrun_ready got=%0b exp=0", cfg_ready); else passed++;
    step();
    rst = 1'b0; cfg_valid = 1'b0;
    total++; if (tap_sel !== 2'd0) $display("FAIL rrun_tap got=%0d exp=0", tap_sel); else passed++;
    total++; if (switch_cnt !== 8'd0) $display("FAIL rrun_count got=%0d exp=0", switch_cnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rrun_ov got=%0b exp=0", out_valid); else passed++;
    edge_n = 0;
    step_to(10);
    total++; if (blank !== 1'b1) $display("FAIL rfill_blank_e10 got=%0b exp=1", blank); else passed++;
    rst = 1'b1; cfg_valid = 1'b1; cfg_tap = 2'd1;
    step();
    rst = 1'b0; cfg_valid = 1'b0;
    total++; if (dut.u_fill.fill_cnt !== 7'd0) $display("FAIL rfill_cnt got=%0d exp=0", dut.u_fill.fill_cnt); else passed++;
    total++; if (tap_sel !== 2'd0) $display("FAIL rfill_tap got=%0d exp=0", tap_sel); else passed++;
    total++; if (blank !== 1'b1) $display("FAIL rfill_blank got=%0b exp=1", blank); else passed++;
    total++; if (switch_cnt !== 8'd0) $display("FAIL rfill_count got=%0d exp=0", switch_cnt); else passed++;
    edge_n = 0;
    step_to(5);
    total++; if (dut.u_fill.fill_cnt !== 7'd5) $display("FAIL rfill_cnt_e5 got=%0d exp=5", dut.u_fill.fill_cnt); else passed++;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    for (int k = 1; k <= 258; k++) begin
      cfg_valid = 1'b1;
      cfg_tap   = (k % 2 == 1) ? 2'd1 : 2'd0;
      step();
      cfg_valid = 1'b0;
      step();
      step();
      exp_cnt = (k > 255) ? 255 : k;
      if (k == 1 || k == 255 || k == 258) begin
        total++;
        if (switch_cnt !== 8'(exp_cnt))
          $display("FAIL sat_count_%0d got=%0d exp=%0d", k, switch_cnt, exp_cnt);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_initial_fill();
    test_switch_unfilled();
    test_switch_filled();
    test_same_tap();
    test_back_to_back();
    test_disable();
    test_reset_mid_run_fill();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/delay_tap_scheduler.md
# delay_tap_scheduler

Controller for the bank of fixed-depth delay lines (30/45/60/90 taps) and the output tap mux. It accepts tap-change requests over a valid/ready handshake and drives the mux select. It blanks the mux output across every switch and during the fill period of the selected line. It asserts `out_valid` only when the selected line holds real data, never reset residue. It sits between the top-level config inputs and the mux, and replaces the raw `uio_in` select path.

## Interface
Parameters:
- `DEPTH0`, default 30: depth of line 0 in cycles.
- `DEPTH1`, default 45: depth of line 1.
- `DEPTH2`, default 60: depth of line 2.
- `DEPTH3`, default 90: depth of line 3; must be the maximum depth.
- `GUARD_CYCLES`, default 2: blanking cycles after every accepted switch, ≥1.
- `CNT_W`, default 7: fill counter width; `2^CNT_W-1` ≥ `DEPTH3`.

Ports:
- `clk`, in, 1: single clock. Delay lines shift on every edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ena`, in, 1: design enable.
- `cfg_valid`, in, 1: tap-change request.
- `cfg_tap`, in, 2: requested line index.
- `cfg_ready`, out, 1: request can be accepted this cycle.
- `tap_sel`, out, 2: registered mux select.
- `blank`, out, 1: registered; forces the mux output to 0.
- `out_valid`, out, 1: registered; selected line output is genuine.
- `switch_cnt`, out, 8: saturating count of effective switches.

## Operation
- Reset values: `tap_sel`=0, `blank`=1, `out_valid`=0, `switch_cnt`=0, state=FILL, `fill_cnt`=0, `guard_cnt`=0. `cfg_ready` is 0 while `rst`=1.
- `fill_cnt` increments on every non-reset edge and saturates at `DEPTH3`. It is independent of `ena` because the lines shift regardless.
- `depth(sel)` is the parameter mux of `DEPTH0..3`.
- `cfg_ready` = `ena` & !`rst` & (state≠GUARD). It is combinational.
- A request is accepted on an edge where `cfg_valid`&`cfg_ready`=1.
- State FILL: `blank`=1, `out_valid`=0. Go to RUN on an edge where pre-edge `fill_cnt` ≥ `depth(tap_sel)`.
- State RUN: `blank`=0, `out_valid`=1.
- State GUARD: `blank`=1, `out_valid`=0. `guard_cnt` is loaded with `GUARD_CYCLES-1` on entry and decrements each edge. At `guard_cnt`=0 the next edge goes to RUN if `fill_cnt` ≥ `depth(tap_sel)`, else FILL.
- Accept with `cfg_tap`≠`tap_sel` (from FILL or RUN): `tap_sel`←`cfg_tap`, state←GUARD, `switch_cnt`+1 (saturates at 255).
- Accept with `cfg_tap`=`tap_sel`: handshake completes; no state change, no count.
- Acceptance takes priority over the FILL→RUN transition on the same edge.
- `ena`=0: state, `tap_sel` and `guard_cnt` hold. Output flags are forced to `blank`=1 and `out_valid`=0 on the next edge. `cfg_ready`=0. On re-enable the flags resume from the held state on the following edge.
- `rst` mid-GUARD or mid-FILL returns everything to reset values on that edge. Any request pending in the same cycle is dropped.

## Timing
- Cycle n = nth rising edge with `rst` sampled 0. After edge n, `fill_cnt` = min(n, `DEPTH3`).
- Reset to first `out_valid` on line 0: high after edge `DEPTH0`+1.
- Accept at edge t: `tap_sel` and `blank` update at t+1. GUARD occupies edges t+1 .. t+`GUARD_CYCLES`. The state after GUARD is registered at edge t+`GUARD_CYCLES`+1.
- Minimum request-to-request spacing is `GUARD_CYCLES`+1 edges.
- All outputs except `cfg_ready` are registered.

## Structure
- Shared package `delay_pkg`: depth constants, the state enum (FILL, RUN, GUARD), and a depth-lookup function.
- One natural sub-module: `fill_tracker`, the saturating `fill_cnt` with per-line ready compares. The FSM lives in the top.

## Test plan
- Reset, `ena`=1, no requests → `blank` falls and `out_valid` rises after edge 31, `tap_sel`=0.
- At edge 40 request tap 3 → `blank`=1 at 41–43, state FILL at 43, `out_valid` high after edge 91, `switch_cnt`=1.
- After edge 100 (lines filled) request tap 2 → guard at 101–102, `out_valid` back high after edge 103.
- Request tap 1 while `tap_sel`=1 → accepted, `out_valid` stays 1, `switch_cnt` unchanged. `cfg_valid` held during GUARD → `cfg_ready`=0, no accept until guard ends.
- `ena`=0 for 5 cycles in RUN → `out_valid`=0 and `cfg_ready`=0 during them. `out_valid` returns 1 one edge after `ena`=1. `fill_cnt` is unaffected.
- `rst` pulse mid-FILL → all outputs at reset values the next cycle. 256 effective switches → `switch_cnt` holds 255.
